// File: rtl/wb_sram_resp_if.sv
// Wishbone pipelined slave bus bundle for wb_sram_resp.
// The o_wb_err signal exists only when WB_SRAM_RESP_ERR_EN is defined.
interface wb_sram_resp_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [31:0] i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;
`ifdef WB_SRAM_RESP_ERR_EN
    logic        o_wb_err;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  o_wb_ack, o_wb_stall, o_wb_data, o_wb_err
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output o_wb_ack, o_wb_stall, o_wb_data, o_wb_err
    );
`else
    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  o_wb_ack, o_wb_stall, o_wb_data
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output o_wb_ack, o_wb_stall, o_wb_data
    );
`endif
endinterface

// File: rtl/wb_sram_resp.sv
// Single-outstanding Wishbone SRAM slave with programmable wait states.
// Define WB_SRAM_RESP_ERR_EN to add o_wb_err for misaligned/out-of-range addresses.
module wb_sram_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          resetn,
    wb_sram_resp_if.slave bus
);
    localparam int         AW      = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          bad_q, bad_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          req;
    logic          bad_in;
    logic [AW-1:0] idx_in;
    logic          fire;
    logic          fire_we;
    logic          fire_bad;
    logic [AW-1:0] mem_idx;
    logic [31:0]   mem_wdata;
    logic          mem_we;

    assign req    = bus.i_wb_cyc & bus.i_wb_stb;
    assign idx_in = bus.i_wb_addr[AW+1:2];

`ifdef WB_SRAM_RESP_ERR_EN
    assign bad_in = (|bus.i_wb_addr[31:AW+2]) | (|bus.i_wb_addr[1:0]);
`else
    // Upper and byte-lane address bits are dropped so accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.i_wb_addr[31:AW+2], bus.i_wb_addr[1:0]};
    assign bad_in           = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        bad_d     = bad_q;
        rdata_d   = rdata_q;
        fire      = 1'b0;
        fire_we   = we_q;
        fire_bad  = bad_q;
        mem_idx   = addr_q;
        mem_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = idx_in;
                    we_d    = bus.i_wb_we;
                    wdata_d = bus.i_wb_data;
                    bad_d   = bad_in;
                    if (WAIT_STATES == 0) begin
                        // Zero wait states: the acceptance edge is also the commit edge.
                        state_d   = ACK;
                        fire      = 1'b1;
                        fire_we   = bus.i_wb_we;
                        fire_bad  = bad_in;
                        mem_idx   = idx_in;
                        mem_wdata = bus.i_wb_data;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!bus.i_wb_cyc) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = ACK;
                    cnt_d   = 4'd0;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        if (fire && !fire_we && !fire_bad) begin
            rdata_d = mem[mem_idx];
        end
    end

    // A clock edge seen while resetn is low must never commit a write.
    assign mem_we = fire & fire_we & ~fire_bad & resetn;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            bad_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            bad_q   <= bad_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: the array has no reset so it maps onto plain RAM; contents survive resetn.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    assign bus.o_wb_stall = (state_q != IDLE);
    assign bus.o_wb_data  = rdata_q;
`ifdef WB_SRAM_RESP_ERR_EN
    assign bus.o_wb_ack   = (state_q == ACK) & ~bad_q;
    assign bus.o_wb_err   = (state_q == ACK) & bad_q;
`else
    assign bus.o_wb_ack   = (state_q == ACK);
`endif
endmodule

// File: tb/tb_wb_sram_resp.sv
// Directed bench for wb_sram_resp: one instance with 0 wait states, one with 3.
// Bus index 0 drives the zero-wait instance, index 1 the three-wait instance.
module tb_wb_sram_resp;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    wb_sram_resp_if b0 ();
    wb_sram_resp_if b3 ();

    logic        cyc_r  [2];
    logic        stb_r  [2];
    logic        we_r   [2];
    logic [31:0] addr_r [2];
    logic [31:0] wdat_r [2];

    assign b0.i_wb_cyc  = cyc_r[0];
    assign b0.i_wb_stb  = stb_r[0];
    assign b0.i_wb_we   = we_r[0];
    assign b0.i_wb_addr = addr_r[0];
    assign b0.i_wb_data = wdat_r[0];
    assign b3.i_wb_cyc  = cyc_r[1];
    assign b3.i_wb_stb  = stb_r[1];
    assign b3.i_wb_we   = we_r[1];
    assign b3.i_wb_addr = addr_r[1];
    assign b3.i_wb_data = wdat_r[1];

    wb_sram_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (.clk(clk), .resetn(resetn), .bus(b0));
    wb_sram_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (.clk(clk), .resetn(resetn), .bus(b3));

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic ack_of(input int s);
        return (s == 0) ? b0.o_wb_ack : b3.o_wb_ack;
    endfunction

    function automatic logic stall_of(input int s);
        return (s == 0) ? b0.o_wb_stall : b3.o_wb_stall;
    endfunction

    function automatic logic [31:0] data_of(input int s);
        return (s == 0) ? b0.o_wb_data : b3.o_wb_data;
    endfunction

    function automatic logic err_of(input int s);
`ifdef WB_SRAM_RESP_ERR_EN
        return (s == 0) ? b0.o_wb_err : b3.o_wb_err;
`else
        return (s == 0) ? 1'b0 : 1'b0;
`endif
    endfunction

    // One transfer from an idle bus; lat counts edges from acceptance to the
    // sampled ack/err, -1 when no response arrives inside the budget.
    task automatic xfer(input int s, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output int stalls, output logic [31:0] rdata, output logic hit_err);
        logic done;
        @(posedge clk); #1;
        cyc_r[s] = 1'b1; stb_r[s] = 1'b1; we_r[s] = we; addr_r[s] = addr; wdat_r[s] = wdata;
        @(posedge clk); #1;
        stb_r[s] = 1'b0;
        lat = 0; stalls = 0; rdata = '0; hit_err = 1'b0; done = 1'b0;
        while (!done && lat < 32) begin
            @(negedge clk);
            lat++;
            if (stall_of(s)) stalls++;
            if (ack_of(s) || err_of(s)) begin
                done    = 1'b1;
                rdata   = data_of(s);
                hit_err = err_of(s);
            end
        end
        if (!done) lat = -1;
        @(posedge clk); #1;
        cyc_r[s] = 1'b0; we_r[s] = 1'b0;
    endtask

    task automatic do_write(input int s, input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        int lat, stl; logic [31:0] rd; logic er;
        xfer(s, 1'b1, addr, wdata, lat, stl, rd, er);
        check({tag, "_lat"}, lat, (s == 0) ? 1 : 4);
        check({tag, "_err"}, 32'(er), 0);
    endtask

    task automatic do_read(input int s, input logic [31:0] addr, input logic [31:0] exp, input string tag);
        int lat, stl; logic [31:0] rd; logic er;
        xfer(s, 1'b0, addr, 32'd0, lat, stl, rd, er);
        check({tag, "_lat"}, lat, (s == 0) ? 1 : 4);
        check({tag, "_data"}, rd, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, stl, hits;
        logic [31:0] rd;
        logic er;

        for (int i = 0; i < 2; i++) begin
            cyc_r[i] = 1'b0; stb_r[i] = 1'b0; we_r[i] = 1'b0; addr_r[i] = '0; wdat_r[i] = '0;
        end
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_ack",   32'(ack_of(i)),   0);
            check("rst_stall", 32'(stall_of(i)), 0);
            check("rst_data",  data_of(i),       0);
        end
        @(negedge clk);
        resetn = 1'b1;

        // Three wait states: read of an unwritten word right after reset.
        xfer(1, 1'b0, 32'h0, 32'd0, lat, stl, rd, er);
        check("ws3_rd0_lat",   lat, 4);
        check("ws3_rd0_stall", stl, 4);
        check("ws3_rd0_data",  rd,  32'h0);

        // Zero wait states: write then read back; stall seen in the ack cycle.
        do_write(0, 32'h10, 32'hDEADBEEF, "ws0_wr10");
        xfer(0, 1'b0, 32'h10, 32'd0, lat, stl, rd, er);
        check("ws0_rd10_lat",   lat, 1);
        check("ws0_rd10_stall", stl, 1);
        check("ws0_rd10_data",  rd,  32'hDEADBEEF);
        xfer(0, 1'b1, 32'h14, 32'h0BADF00D, lat, stl, rd, er);
        check("ws0_wrack_holds_data", rd, 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        check("ws0_idle_holds_data", data_of(0), 32'hDEADBEEF);
        do_read(0, 32'h14, 32'h0BADF00D, "ws0_rd14");
        do_read(0, 32'h3FC, 32'h0, "ws0_unwritten");

        // Strobe without cycle is ignored.
        @(posedge clk); #1;
        cyc_r[0] = 1'b0; stb_r[0] = 1'b1; we_r[0] = 1'b1; addr_r[0] = 32'h10; wdat_r[0] = 32'h00000BAD;
        hits = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack_of(0) || stall_of(0)) hits++;
        end
        @(posedge clk); #1;
        stb_r[0] = 1'b0; we_r[0] = 1'b0;
        check("nocyc_no_response", hits, 0);
        do_read(0, 32'h10, 32'hDEADBEEF, "nocyc_rd10");

        // Write aborted by dropping cyc two cycles after acceptance.
        @(posedge clk); #1;
        cyc_r[1] = 1'b1; stb_r[1] = 1'b1; we_r[1] = 1'b1; addr_r[1] = 32'h20; wdat_r[1] = 32'h12345678;
        @(posedge clk); #1;
        stb_r[1] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        cyc_r[1] = 1'b0; we_r[1] = 1'b0;
        hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack_of(1) || err_of(1)) hits++;
        end
        check("abort_no_ack",   hits, 0);
        check("abort_stall_lo", 32'(stall_of(1)), 0);
        do_read(1, 32'h20, 32'h0, "abort_rd20");

        // Address wrap-around versus error response.
        xfer(0, 1'b1, 32'h1004, 32'hA5A5A5A5, lat, stl, rd, er);
        check("wrap_wr_lat", lat, 1);
`ifdef WB_SRAM_RESP_ERR_EN
        check("wrap_wr_err", 32'(er), 1);
        do_read(0, 32'h4, 32'h0, "wrap_rd4");
`else
        check("wrap_wr_err", 32'(er), 0);
        do_read(0, 32'h4, 32'hA5A5A5A5, "wrap_rd4");
`endif

        // Continuous strobe: four reads, acks two cycles apart in order.
        for (int i = 0; i < 4; i++) do_write(0, 32'(i * 4), 32'hC0DE0000 + 32'(i), "pipe_wr");
        begin : pipe
            int nack, idx, cyc_n;
            int when [4];
            logic [31:0] got [4];
            logic s;
            nack = 0; idx = 0; cyc_n = 0;
            for (int i = 0; i < 4; i++) begin when[i] = 0; got[i] = '0; end
            @(posedge clk); #1;
            cyc_r[0] = 1'b1; stb_r[0] = 1'b1; we_r[0] = 1'b0; addr_r[0] = 32'h0;
            while (nack < 4 && cyc_n < 40) begin
                @(negedge clk);
                cyc_n++;
                s = stall_of(0);
                if (ack_of(0)) begin
                    if (nack < 4) begin
                        got[nack]  = data_of(0);
                        when[nack] = cyc_n;
                    end
                    nack++;
                end
                @(posedge clk); #1;
                if (!s && stb_r[0] && idx < 4) idx++;
                if (idx == 4) stb_r[0] = 1'b0;
                else addr_r[0] = 32'(idx * 4);
            end
            cyc_r[0] = 1'b0; stb_r[0] = 1'b0;
            check("pipe_ack_count", nack, 4);
            for (int i = 0; i < 4; i++) check("pipe_data", got[i], 32'hC0DE0000 + 32'(i));
            for (int i = 1; i < 4; i++) check("pipe_spacing", when[i] - when[i-1], 2);
        end

        // Reset during WAIT of a write; dut0 request pending across reset release.
        do_write(1, 32'h40, 32'h11112222, "rst_pre_wr40");
        do_read(1, 32'h40, 32'h11112222, "rst_pre_rd40");
        @(posedge clk); #1;
        cyc_r[1] = 1'b1; stb_r[1] = 1'b1; we_r[1] = 1'b1; addr_r[1] = 32'h40; wdat_r[1] = 32'h33334444;
        @(posedge clk); #1;
        stb_r[1] = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        check("midrst_ack",   32'(ack_of(1)),   0);
        check("midrst_stall", 32'(stall_of(1)), 0);
        check("midrst_data",  data_of(1),       0);
        cyc_r[1] = 1'b0; we_r[1] = 1'b0;
        cyc_r[0] = 1'b1; stb_r[0] = 1'b1; we_r[0] = 1'b0; addr_r[0] = 32'h10;
        hits = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack_of(1) || ack_of(0)) hits++;
        end
        check("midrst_no_ack", hits, 0);
        resetn = 1'b1;
        @(posedge clk); #1;
        stb_r[0] = 1'b0;
        @(negedge clk);
        check("first_edge_ack",  32'(ack_of(0)), 1);
        check("first_edge_data", data_of(0),     32'hDEADBEEF);
        @(posedge clk); #1;
        cyc_r[0] = 1'b0;
        do_read(1, 32'h40, 32'h11112222, "postrst_rd40");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_sram_resp.md
WB_SRAM_RESP -- requirements
Module: wb_sram_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: memory size in 32-bit words; power of two, 16 to 65536.
REQ-002 Parameter WAIT_STATES, default 0: extra cycles inserted before ack; range 0 to 15.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 resetn  input  1  asynchronous assert, active-low reset.
REQ-005 i_wb_cyc  input  1  Wishbone bus cycle active.
REQ-006 i_wb_stb  input  1  Wishbone strobe; request valid when i_wb_cyc is also high.
REQ-007 i_wb_we  input  1  1 = write, 0 = read.
REQ-008 i_wb_addr  input  32  byte address; word index = i_wb_addr[AW+1:2], AW = log2(DEPTH_WORDS).
REQ-009 i_wb_data  input  32  write data; full-word writes only.
REQ-010 o_wb_ack  output  1  single-cycle transfer acknowledge.
REQ-011 o_wb_stall  output  1  pipelined-mode stall; request is accepted only on an edge where o_wb_stall=0.
REQ-012 o_wb_data  output  32  read data, valid only while o_wb_ack=1.

Function
REQ-013 The block shall use FSM states IDLE, WAIT and ACK.
REQ-014 In IDLE, o_wb_stall=0, and the block shall accept the request on any edge where i_wb_cyc=1 and i_wb_stb=1.
REQ-015 On acceptance, the block shall latch address, we and data, and go to WAIT if WAIT_STATES>0, otherwise to ACK.
REQ-016 In WAIT, a down-counter loaded with WAIT_STATES shall decrement each cycle; the block shall enter ACK on the edge where the counter reaches 1.
REQ-017 o_wb_ack shall be 1 for exactly one cycle, in ACK, and ack shall appear WAIT_STATES+1 cycles after the acceptance edge.
REQ-018 o_wb_stall shall be 1 in WAIT and ACK: one outstanding request maximum, peak throughput one transfer per WAIT_STATES+2 cycles.
REQ-019 A write shall be committed to memory on the edge entering ACK; a read shall sample memory on that same edge, so o_wb_data is registered.
REQ-020 o_wb_data shall hold its last read value outside ack cycles; a write ack shall leave o_wb_data unchanged.
REQ-021 From ACK, the next state shall be IDLE; back-to-back requests shall be re-accepted from IDLE only.
REQ-022 i_wb_stb with i_wb_cyc=0 shall be ignored.
REQ-023 If i_wb_cyc drops while in WAIT, the block shall abort: return to IDLE next edge, no ack, no memory write.
REQ-024 If i_wb_cyc drops in the ACK cycle, ack shall still be driven and the write is already committed.
REQ-025 Address bits above AW+1 shall be ignored (wrap-around), and address bits [1:0] shall be ignored, unless WB_SRAM_RESP_ERR_EN is defined.
REQ-026 A read from a never-written word shall return the memory initial value, 0.

Reset
REQ-027 While resetn=0, the block shall force FSM=IDLE, o_wb_ack=0, o_wb_stall=0, o_wb_data=0 and the wait counter to 0, asynchronously.
REQ-028 Reset asserted mid-transaction shall drop the transaction with no ack; an uncommitted write shall not occur.
REQ-029 Memory contents shall not be cleared by reset.
REQ-030 The first request shall be accepted on the first edge after resetn deasserts.

Configuration
REQ-031 Macro WB_SRAM_RESP_ERR_EN, when defined, shall add output o_wb_err (1 bit, reset 0).
REQ-032 With WB_SRAM_RESP_ERR_EN defined, an accepted request shall complete with o_wb_err=1 instead of o_wb_ack, with identical timing, if any of the following hold: i_wb_addr[31:AW+2] is nonzero, or i_wb_addr[1:0] is nonzero.
REQ-033 With WB_SRAM_RESP_ERR_EN defined, an errored write shall not modify memory, and an errored read shall leave o_wb_data unchanged.
REQ-034 Without WB_SRAM_RESP_ERR_EN, there shall be no o_wb_err port and addressing shall wrap per REQ-025.

Verification
REQ-035 WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 -> each ack arrives 1 cycle after acceptance, read returns 0xDEADBEEF, stall=1 during the ack cycle.
REQ-036 WAIT_STATES=3: read 0x0 after reset -> ack exactly 4 cycles after acceptance, stall high 4 cycles, data 0x00000000.
REQ-037 WAIT_STATES=3: write 0x12345678 to 0x20, drop cyc 2 cycles after acceptance, then read 0x20 -> no ack for the aborted write, read returns the prior value 0.
REQ-038 DEPTH_WORDS=1024: write 0xA5A5A5A5 to 0x1004, read 0x0004 -> returns 0xA5A5A5A5 without ERR_EN; with ERR_EN, the write gets o_wb_err=1 and the read returns 0.
REQ-039 Pull resetn low during WAIT of a write to 0x40 -> outputs go to 0 immediately, with no ack; after reset, read 0x40 returns its old value.
REQ-040 With stb held high continuously for 4 reads at 0x0, 0x4, 0x8 and 0xC, WAIT_STATES=0 -> exactly 4 acks, each spaced 2 cycles apart, in address order.
